rca_seq_wide_adder: RTL and testbench
=====================================

Name: rca_seq_wide_adder

Overview:
- Multi-cycle sequencer that adds two NWORDS×16-bit operands by time-multiplexing one 16-bit two-operand ripple-carry adder (rca_2op_16bit), one 16-bit word per cycle, least-significant word first.
- Carry out of each word is registered and fed back as the next word's carry-in.
- Sits between an operand producer and a result consumer; both sides use a valid/ready handshake.
- Provides wide-precision addition (64-bit by default) at single 16-bit-adder area.

Parameters:
- NWORDS, 4, number of 16-bit words per operand; legal range 1..16; operand width W = 16*NWORDS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept an operand set.
- a  input  W  operand A; captured on the input handshake.
- b  input  W  operand B; captured on the input handshake.
- cin  input  1  initial carry-in; captured on the input handshake.
- out_valid  output  1  result on sum is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W+1  result; sum[W] is the final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - rst is sampled on the rising edge of clk and overrides all other inputs.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, word index k=0, carry register c=0.
  - Operand registers are don't-care.
- Datapath:
  - Exactly one rca_2op_16bit instance.
  - Inputs each cycle: A=a_reg word k, B=b_reg word k, Cin=c.
  - Its 17-bit output gives the 16 sum bits and the carry-out.
  - No other adders are permitted.
- FSM:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: capture a, b, cin; set c=cin, k=0; clear sum; go to RUN.
  - RUN:
    - in_ready=0.
    - Each cycle: write adder sum bits into sum[16k+15:16k]; set c=adder carry-out.
    - If k==NWORDS-1: write carry-out into sum[W]; go to DONE. Otherwise k=k+1.
  - DONE:
    - out_valid=1; sum is held stable.
    - On out_ready: set out_valid=0 and go to IDLE in the same edge.
- Latency and throughput:
  - Input handshake edge to out_valid high is NWORDS+1 cycles.
  - Minimum spacing between accepted operand sets is NWORDS+2 cycles.
- Handshake rules:
  - in_ready is low in RUN and DONE. in_valid asserted while in_ready=0 is ignored; the producer holds its data.
  - sum and out_valid stay stable while out_valid=1 and out_ready=0, for any number of cycles.
  - out_ready asserted outside DONE has no effect.
- Boundary conditions:
  - NWORDS=1: RUN lasts one cycle; behaviour equals a single registered 16-bit add.
  - Carry ripple across word boundaries: a carry generated in word k must appear in word k+1 in the next cycle. Example: all-ones + 1 propagates through every word.
  - Wrap-around: the result is exact over W+1 bits; no truncation and no saturation.
  - Reset mid-operation (RUN or DONE): the operation aborts and no result is produced. The next cycle is IDLE with reset values.
  - in_valid and rst together: rst wins and nothing is captured.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN.
- With the macro defined:
  - Extra port sub, input, 1 bit, captured with the operands on the input handshake.
  - When sub=1: each B word is bitwise inverted before the adder; the initial c is forced to 1 and cin is ignored.
  - sum = A − B in two's complement over W bits. sum[W]=1 means no borrow (A>=B unsigned).
  - When sub=0: behaviour is identical to the build without the macro.
- Without the macro: port sub is absent; the block is addition only.

Test Plan:
1. Reset, then idle: in_ready=1, out_valid=0, sum=0, busy=0.
2. NWORDS=4 carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → out_valid exactly 5 cycles after the handshake; sum=65'h1_0000_0000_0000_0000.
3. Back-pressure: a=64'h0001_0002_0003_0004, b=64'h0010_0020_0030_0040, cin=1. Hold out_ready=0 for 10 cycles → sum=65'h0_0011_0022_0033_0045 stays stable throughout; in_ready=0 with in_valid high; release out_ready → IDLE next cycle.
4. Reset in RUN: assert rst when k=2 → next cycle in_ready=1, out_valid=0, sum=0; no result is ever emitted for that operand set.
5. Back-to-back: present in_valid continuously with two operand sets → second accepted exactly 6 cycles after the first; both sums correct (e.g. 0+0+cin=1 → sum=1).
6. RCA_SEQ_SUB_EN, sub=1: a=64'h5, b=64'h7 → sum[63:0]=64'hFFFF_FFFF_FFFF_FFFE, sum[64]=0. Then a=7, b=5 → sum=65'h1_0000_0000_0000_0002.

Source files
------------

// File: rtl/rca_seq_wide_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : rca_seq_wide_adder_if
//  Description : Operand/result handshake bundle for rca_seq_wide_adder.
//                Producer side drives in_valid/a/b/cin (and sub when
//                RCA_SEQ_SUB_EN is defined); consumer side drives out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rca_seq_wide_adder_if #(
    parameter int NWORDS = 4
);
    localparam int c_W = 16 * NWORDS;

    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [c_W:0]   sum;
    logic           busy;
`ifdef RCA_SEQ_SUB_EN
    logic           sub;
`endif

`ifdef RCA_SEQ_SUB_EN
    // Producer/consumer view
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, busy
    );

    // Adder view
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, busy
    );
`else
    // Producer/consumer view
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, busy
    );

    // Adder view
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, busy
    );
`endif

endinterface : rca_seq_wide_adder_if
`default_nettype wire

// File: rtl/rca_seq_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module      : rca_seq_wide_adder (+ rca_2op_16bit)
//  Description : Wide (16*NWORDS bit) adder built from a single 16-bit
//                ripple-carry adder, one word per cycle, LSW first. The word
//                carry is registered and fed back as the next word's carry-in.
//                Valid/ready handshake on both operand and result sides.
//                Optional macro RCA_SEQ_SUB_EN adds a 'sub' input selecting
//                A - B (two's complement, sum[W]=1 means no borrow).
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 16-bit two-operand ripple-carry adder; o_y[16] is the carry-out.
// ----------------------------------------------------------------------------
module rca_2op_16bit (
    input  wire logic [15:0] i_a,
    input  wire logic [15:0] i_b,
    input  wire logic        i_cin,
    output logic      [16:0] o_y
);
    logic w_carry;

    // Bit-serial carry ripple through 16 full-adder cells
    always_comb begin
        o_y     = '0;
        w_carry = i_cin;
        for (int i = 0; i < 16; i++) begin
            o_y[i]  = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_y[16] = w_carry;
    end
endmodule : rca_2op_16bit

// ----------------------------------------------------------------------------
// Word-serial wide adder sequencer
// ----------------------------------------------------------------------------
module rca_seq_wide_adder #(
    parameter int NWORDS = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rca_seq_wide_adder_if.slave   bus
);
    localparam int c_W  = 16 * NWORDS;
    localparam int c_KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(NWORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [c_W-1:0]  r_a;
    logic [c_W-1:0]  r_b;
    logic [c_KW-1:0] r_k;
    logic            r_c;
    logic [c_W:0]    r_sum;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
`ifdef RCA_SEQ_SUB_EN
    logic            r_sub;
`endif

    logic [15:0]     w_a_word;
    logic [15:0]     w_b_word;
    logic [15:0]     w_b_opnd;
    logic            w_cin_init;
    logic [16:0]     w_y;

    // Select word k of each captured operand; subtraction inverts B and
    // forces the initial carry to 1 so the adder computes A + ~B + 1.
    always_comb begin
        w_a_word = 16'(r_a >> {r_k, 4'b0000});
        w_b_word = 16'(r_b >> {r_k, 4'b0000});
`ifdef RCA_SEQ_SUB_EN
        w_b_opnd   = r_sub ? ~w_b_word : w_b_word;
        w_cin_init = bus.sub ? 1'b1 : bus.cin;
`else
        w_b_opnd   = w_b_word;
        w_cin_init = bus.cin;
`endif
    end

    rca_2op_16bit u_rca (
        .i_a   (w_a_word),
        .i_b   (w_b_opnd),
        .i_cin (r_c),
        .o_y   (w_y)
    );

    // Sequencer: capture on handshake, one word per cycle, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sum       <= '0;
            r_k         <= '0;
            r_c         <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_c        <= w_cin_init;
`ifdef RCA_SEQ_SUB_EN
                        r_sub      <= bus.sub;
`endif
                        r_k        <= '0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_RUN;
                    end
                end
                c_RUN: begin
                    for (int w = 0; w < NWORDS; w++) begin
                        if (r_k == c_KW'(w)) begin
                            r_sum[16*w +: 16] <= w_y[15:0];
                        end
                    end
                    r_c <= w_y[16];
                    if (r_k == c_K_LAST) begin
                        r_sum[c_W]  <= w_y[16];
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;

endmodule : rca_seq_wide_adder
`default_nettype wire

// File: tb/tb_rca_seq_wide_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rca_seq_wide_adder
//  Description : Self-checking bench for rca_seq_wide_adder (NWORDS=4).
//                Table of directed add vectors plus hand-written sequences
//                for back-pressure, reset mid-run, rst/in_valid collision,
//                back-to-back operands and (with RCA_SEQ_SUB_EN) subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_seq_wide_adder;
    localparam int NWORDS = 4;
    localparam int c_LAT  = NWORDS + 1;
    localparam int c_GAP  = NWORDS + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    rca_seq_wide_adder_if #(.NWORDS(NWORDS)) bus ();

    rca_seq_wide_adder #(.NWORDS(NWORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [64:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One full transaction from IDLE; lat counts cycles from the handshake
    // cycle (cycle 0) to the first cycle with out_valid high.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          output logic [64:0] s, output int lat);
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        s = bus.sum;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [64:0] s;
        int          lat;
        int          acc_t[2];
        int          res_t[2];
        logic [64:0] res_s[2];
        int          n_acc;
        int          n_res;
        logic        acc;
        logic        seen;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 65'h1_0000_0000_0000_0000};
        vecs[1] = '{64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 65'h0_0011_0022_0033_0045};
        vecs[2] = '{64'h0, 64'h0, 1'b1, 65'h0_0000_0000_0000_0001};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000};
        vecs[5] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 65'h0_0001_0000_0001_0000};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 65'h0_2345_6789_ABCD_F001};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_busy", bus.busy, 0);

        // out_ready outside DONE does nothing
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("idle_out_ready", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);

        // Table-driven additions
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, lat);
            check($sformatf("vec%0d_sum", i), s, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), lat, c_LAT);
        end

        // Back-pressure: result held while out_ready low, in_valid ignored
        bus.a         = 64'h0001_0002_0003_0004;
        bus.b         = 64'h0010_0020_0030_0040;
        bus.cin       = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        check("bp_lat", lat, c_LAT);
        for (int i = 0; i < 10; i++) begin
            check("bp_sum", bus.sum, 65'h0_0011_0022_0033_0045);
            check("bp_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_release", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);

        // Reset while in RUN with k=2
        bus.a        = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b        = 64'h1;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        check("run_busy", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        check("abort_sum", bus.sum, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        check("abort_no_result", seen, 0);

        // rst and in_valid together: nothing captured
        bus.a        = 64'h5;
        bus.b        = 64'h5;
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_win_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        step();
        check("rst_win_idle", bus.busy, 0);

        // Back-to-back operand sets with continuous in_valid and out_ready
        bus.a         = 64'h0;
        bus.b         = 64'h0;
        bus.cin       = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n_acc = 0;
        n_res = 0;
        acc_t = '{0, 0};
        res_t = '{0, 0};
        res_s = '{65'h0, 65'h0};
        for (int t = 0; t < 30; t++) begin
            if (bus.out_valid && n_res < 2) begin
                res_t[n_res] = t;
                res_s[n_res] = bus.sum;
                n_res++;
            end
            acc = bus.in_ready && bus.in_valid;
            step();
            if (acc && n_acc < 2) begin
                acc_t[n_acc] = t;
                n_acc++;
                if (n_acc == 1) begin
                    bus.a   = 64'h0000_0000_0000_FFFF;
                    bus.b   = 64'h1;
                    bus.cin = 1'b0;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.out_ready = 1'b0;
        check("b2b_accepts", n_acc, 2);
        check("b2b_gap", acc_t[1] - acc_t[0], c_GAP);
        check("b2b_results", n_res, 2);
        check("b2b_lat", res_t[0] - acc_t[0], c_LAT);
        check("b2b_sum0", res_s[0], 65'h1);
        check("b2b_sum1", res_s[1], 65'h0_0000_0000_0001_0000);

`ifdef RCA_SEQ_SUB_EN
        // Subtraction: cin is ignored when sub=1
        bus.sub = 1'b1;
        run_op(64'h5, 64'h7, 1'b0, s, lat);
        check("sub_5_7", s, 65'h0_FFFF_FFFF_FFFF_FFFE);
        run_op(64'h7, 64'h5, 1'b1, s, lat);
        check("sub_7_5", s, 65'h1_0000_0000_0000_0002);
        bus.sub = 1'b0;
        run_op(64'h7, 64'h5, 1'b1, s, lat);
        check("sub0_add", s, 65'h0_0000_0000_0000_000D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rca_seq_wide_adder
`default_nettype wire
